// File: rtl/clock_pkg.sv
// Shared types, mode encodings, field limits and BCD conversion helpers
// for the clock timekeeper.
package clock_pkg;

  typedef logic [7:0] bcd_t;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10
  } mode_e;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  function automatic int unsigned bcd2bin(input bcd_t b);
    return 10 * 32'(b[7:4]) + 32'(b[3:0]);
  endfunction

  function automatic bcd_t bin2bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/clock_timekeeper_if.sv
// Slow-clock, key and display-side signals of the timekeeper, bundled so the
// divider/key side and the timekeeper see matching directions.
interface clock_timekeeper_if;
  import clock_pkg::*;

  logic       clk_1hz;
  logic       clk_2hz;
  logic       key_mode;
  logic       key_inc;
  bcd_t       hour_bcd;
  bcd_t       min_bcd;
  bcd_t       sec_bcd;
  logic [1:0] mode;
  logic       blank_hr;
  logic       blank_min;
  logic       chime;

  modport master (
    output clk_1hz, clk_2hz, key_mode, key_inc,
    input  hour_bcd, min_bcd, sec_bcd, mode, blank_hr, blank_min, chime
  );

  modport slave (
    input  clk_1hz, clk_2hz, key_mode, key_inc,
    output hour_bcd, min_bcd, sec_bcd, mode, blank_hr, blank_min, chime
  );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX; carry flags the wrap
// combinationally so the next field can advance in the same cycle.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic clk,
  input  logic cr,
  input  logic inc,
  input  logic clr,
  output bcd_t bcd,
  output logic carry
);

  localparam bcd_t MAX_BCD = bin2bcd(MAX);

  bcd_t bcd_q, bcd_d;
  logic legal;

  always_comb begin
    legal = (bcd_q[3:0] <= 4'd9) && (bcd2bin(bcd_q) <= MAX);
    bcd_d = bcd_q;
    if (clr) begin
      bcd_d = '0;
    end else if (inc) begin
      // An out-of-range pattern recovers to 00 on its next increment.
      if (!legal || (bcd_q == MAX_BCD)) begin
        bcd_d = '0;
      end else if (bcd_q[3:0] == 4'd9) begin
        bcd_d = {bcd_q[7:4] + 4'd1, 4'd0};
      end else begin
        bcd_d = {bcd_q[7:4], bcd_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!cr) begin
      bcd_q <= '0;
    end else begin
      bcd_q <= bcd_d;
    end
  end

  assign bcd   = bcd_q;
  assign carry = inc & (bcd_q == MAX_BCD);

endmodule

// File: rtl/clock_timekeeper.sv
// 24-hour BCD timekeeper: synchronises the divided clocks and keys, runs the
// RUN/SET_HR/SET_MIN mode machine and drives blank and pre-chime flags.
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned CHIME_START = 55
) (
  input  logic               clk_50m,
  input  logic               cr,
  clock_timekeeper_if.slave  tk
);

  localparam int NIN      = 4;
  localparam int IDX_1HZ  = 0;
  localparam int IDX_2HZ  = 1;
  localparam int IDX_MODE = 2;
  localparam int IDX_INC  = 3;

  logic [NIN-1:0] lvl;
  logic [NIN-1:0] pulse;

  assign lvl = {tk.key_inc, tk.key_mode, tk.clk_2hz, tk.clk_1hz};

  for (genvar g = 0; g < NIN; g++) begin : g_edge
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], lvl[g]};
      prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_50m) begin
      if (!cr) begin
        sync_q <= '0;
        prev_q <= 1'b0;
      end else begin
        sync_q <= sync_d;
        prev_q <= prev_d;
      end
    end

    assign pulse[g] = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  logic p_1hz, p_2hz, p_mode, p_inc;
  assign p_1hz  = pulse[IDX_1HZ];
  assign p_2hz  = pulse[IDX_2HZ];
  assign p_mode = pulse[IDX_MODE];
  assign p_inc  = pulse[IDX_INC];

  mode_e mode_q, mode_d;
  logic  blink_q, blink_d;
  logic  blank_hr_q, blank_hr_d;
  logic  blank_min_q, blank_min_d;
  logic  chime_q, chime_d;

  always_comb begin
    mode_d = mode_q;
    if (p_mode) begin
      unique case (mode_q)
        MODE_RUN:    mode_d = MODE_SET_HR;
        MODE_SET_HR: mode_d = MODE_SET_MIN;
        default:     mode_d = MODE_RUN;
      endcase
    end
  end

  logic tick_run, enter_set, set_hr_inc, set_min_inc;
  logic sec_carry, min_carry, unused_hour_carry;
  logic min_inc, hour_inc;
  bcd_t sec_bcd, min_bcd, hour_bcd;

  // key_mode takes the cycle: a coincident key_inc is dropped.
  assign tick_run    = p_1hz & (mode_q == MODE_RUN);
  assign enter_set   = p_mode & (mode_q == MODE_RUN);
  assign set_hr_inc  = p_inc & ~p_mode & (mode_q == MODE_SET_HR);
  assign set_min_inc = p_inc & ~p_mode & (mode_q == MODE_SET_MIN);
  assign min_inc     = sec_carry | set_min_inc;
  assign hour_inc    = (min_carry & (mode_q == MODE_RUN)) | set_hr_inc;

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk   (clk_50m),
    .cr    (cr),
    .inc   (tick_run),
    .clr   (enter_set),
    .bcd   (sec_bcd),
    .carry (sec_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk   (clk_50m),
    .cr    (cr),
    .inc   (min_inc),
    .clr   (1'b0),
    .bcd   (min_bcd),
    .carry (min_carry)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk   (clk_50m),
    .cr    (cr),
    .inc   (hour_inc),
    .clr   (1'b0),
    .bcd   (hour_bcd),
    .carry (unused_hour_carry)
  );

  int unsigned sec_bin, min_bin;
  logic        sec_in_window;

  always_comb begin
    blink_d     = blink_q ^ p_2hz;
    blank_hr_d  = (mode_d == MODE_SET_HR) & blink_d;
    blank_min_d = (mode_d == MODE_SET_MIN) & blink_d;
    sec_bin     = bcd2bin(sec_bcd);
    min_bin     = bcd2bin(min_bcd);
    // Judge the window on the post-tick seconds so chime lines up with sec_bcd.
    if (tick_run) begin
      sec_in_window = (sec_bin + 1 >= CHIME_START) && (sec_bin < SEC_MAX);
    end else begin
      sec_in_window = (sec_bin >= CHIME_START);
    end
    chime_d = (mode_d == MODE_RUN) && (min_bin == MIN_MAX) && sec_in_window;
  end

  always_ff @(posedge clk_50m) begin
    if (!cr) begin
      mode_q      <= MODE_RUN;
      blink_q     <= 1'b0;
      blank_hr_q  <= 1'b0;
      blank_min_q <= 1'b0;
      chime_q     <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      blink_q     <= blink_d;
      blank_hr_q  <= blank_hr_d;
      blank_min_q <= blank_min_d;
      chime_q     <= chime_d;
    end
  end

  assign tk.hour_bcd  = hour_bcd;
  assign tk.min_bcd   = min_bcd;
  assign tk.sec_bcd   = sec_bcd;
  assign tk.mode      = mode_q;
  assign tk.blank_hr  = blank_hr_q;
  assign tk.blank_min = blank_min_q;
  assign tk.chime     = chime_q;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Directed and randomized bench for clock_timekeeper, compared against a
// wall-clock reference model kept in plain integers.
module tb_clock_timekeeper;

  localparam int SYNC  = 2;
  localparam int CHIME = 55;

  logic clk = 1'b0;
  logic cr;

  clock_timekeeper_if bus ();

  clock_timekeeper #(.SYNC_STAGES(SYNC), .CHIME_START(CHIME)) dut (
    .clk_50m (clk),
    .cr      (cr),
    .tk      (bus)
  );

  always #10 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: time as plain integers, mode 0/1/2, blink phase.
  int mh, mm, ms, mmode, mblink;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mh = 0; mm = 0; ms = 0; mmode = 0; mblink = 0;
  endtask

  task automatic m_tick();
    ms++;
    if (ms == 60) begin
      ms = 0;
      mm++;
      if (mm == 60) begin
        mm = 0;
        mh = (mh + 1) % 24;
      end
    end
  endtask

  task automatic model_apply(input bit t1, input bit t2, input bit km, input bit ki);
    if (t1 && mmode == 0) m_tick();
    if (t2) mblink ^= 1;
    if (km) begin
      case (mmode)
        0:       begin ms = 0; mmode = 1; end
        1:       mmode = 2;
        default: mmode = 0;
      endcase
    end else if (ki) begin
      if (mmode == 1) mh = (mh + 1) % 24;
      else if (mmode == 2) mm = (mm + 1) % 60;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " hour"}, bus.hour_bcd, to_bcd(mh));
    chk({tag, " min"}, bus.min_bcd, to_bcd(mm));
    chk({tag, " sec"}, bus.sec_bcd, to_bcd(ms));
    chk({tag, " mode"}, {6'b0, bus.mode}, 8'(mmode));
    chk({tag, " blank_hr"}, {7'b0, bus.blank_hr}, (mmode == 1 && mblink == 1) ? 8'd1 : 8'd0);
    chk({tag, " blank_min"}, {7'b0, bus.blank_min}, (mmode == 2 && mblink == 1) ? 8'd1 : 8'd0);
    chk({tag, " chime"}, {7'b0, bus.chime},
        (mmode == 0 && mm == 59 && ms >= CHIME) ? 8'd1 : 8'd0);
  endtask

  // Raise the selected levels together, hold, drop, let them settle, then check.
  task automatic op(input bit t1, input bit t2, input bit km, input bit ki, input string tag);
    @(posedge clk); #1;
    bus.clk_1hz = t1; bus.clk_2hz = t2; bus.key_mode = km; bus.key_inc = ki;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    bus.clk_1hz = 1'b0; bus.clk_2hz = 1'b0; bus.key_mode = 1'b0; bus.key_inc = 1'b0;
    repeat (SYNC + 2 + $urandom_range(0, 2)) @(posedge clk);
    #1;
    model_apply(t1, t2, km, ki);
    check_all(tag);
  endtask

  task automatic set_hm(input int h, input int m);
    op(1'b0, 1'b0, 1'b1, 1'b0, "to_set_hr");
    repeat ((h - mh + 24) % 24) op(1'b0, 1'b0, 1'b0, 1'b1, "inc_hr");
    op(1'b0, 1'b0, 1'b1, 1'b0, "to_set_min");
    repeat ((m - mm + 60) % 60) op(1'b0, 1'b0, 1'b0, 1'b1, "inc_min");
    op(1'b0, 1'b0, 1'b1, 1'b0, "to_run");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cr = 1'b0;
    bus.clk_1hz = 1'b0; bus.clk_2hz = 1'b0; bus.key_mode = 1'b0; bus.key_inc = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    check_all("reset");
    cr = 1'b1;

    // First tick: not visible after SYNC edges, visible two edges later.
    @(posedge clk); #1;
    bus.clk_1hz = 1'b1;
    repeat (SYNC) @(posedge clk);
    #1;
    chk("latency_early sec", bus.sec_bcd, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("latency_late sec", bus.sec_bcd, 8'h01);
    bus.clk_1hz = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
    m_tick();
    repeat (59) op(1'b1, 1'b0, 1'b0, 1'b0, "run_tick");
    chk("sixty_ticks sec", bus.sec_bcd, 8'h00);
    chk("sixty_ticks min", bus.min_bcd, 8'h01);
    chk("sixty_ticks hour", bus.hour_bcd, 8'h00);

    // Midnight rollover and chime window.
    set_hm(23, 59);
    for (int i = 1; i <= 58; i++) begin
      op(1'b1, 1'b0, 1'b0, 1'b0, "to_2359");
      if (i == 54) chk("chime_at_54", {7'b0, bus.chime}, 8'd0);
      if (i == 55) chk("chime_at_55", {7'b0, bus.chime}, 8'd1);
    end
    op(1'b1, 1'b0, 1'b0, 1'b0, "tick_235959");
    chk("235959 hour", bus.hour_bcd, 8'h23);
    chk("235959 min", bus.min_bcd, 8'h59);
    chk("235959 sec", bus.sec_bcd, 8'h59);
    chk("235959 chime", {7'b0, bus.chime}, 8'd1);
    op(1'b1, 1'b0, 1'b0, 1'b0, "tick_midnight");
    chk("midnight hour", bus.hour_bcd, 8'h00);
    chk("midnight min", bus.min_bcd, 8'h00);
    chk("midnight sec", bus.sec_bcd, 8'h00);
    chk("midnight chime", {7'b0, bus.chime}, 8'd0);

    // 12:34:56, enter SET_HR, ticks frozen, hour wraps via key_inc.
    set_hm(12, 34);
    repeat (56) op(1'b1, 1'b0, 1'b0, 1'b0, "to_123456");
    chk("123456 sec", bus.sec_bcd, 8'h56);
    op(1'b0, 1'b0, 1'b1, 1'b0, "enter_set_hr");
    chk("enter_set_hr mode", {6'b0, bus.mode}, 8'h01);
    chk("enter_set_hr sec", bus.sec_bcd, 8'h00);
    repeat (3) op(1'b1, 1'b0, 1'b0, 1'b0, "set_hr_tick");
    chk("frozen sec", bus.sec_bcd, 8'h00);
    repeat (13) op(1'b0, 1'b0, 1'b0, 1'b1, "set_hr_inc");
    chk("hour_wrap hour", bus.hour_bcd, 8'h01);

    // SET_MIN wrap without carry into hour, then resume counting.
    op(1'b0, 1'b0, 1'b1, 1'b0, "enter_set_min");
    chk("enter_set_min mode", {6'b0, bus.mode}, 8'h02);
    repeat (25) op(1'b0, 1'b0, 1'b0, 1'b1, "set_min_inc");
    chk("min59 min", bus.min_bcd, 8'h59);
    op(1'b0, 1'b0, 1'b0, 1'b1, "min_wrap");
    chk("min_wrap min", bus.min_bcd, 8'h00);
    chk("min_wrap hour", bus.hour_bcd, 8'h01);
    op(1'b0, 1'b0, 1'b1, 1'b0, "back_to_run");
    chk("back_to_run mode", {6'b0, bus.mode}, 8'h00);
    op(1'b1, 1'b0, 1'b0, 1'b0, "resume_tick");
    chk("resume sec", bus.sec_bcd, 8'h01);

    // key_mode beats key_inc; blink toggles blank_hr only.
    op(1'b0, 1'b0, 1'b1, 1'b1, "mode_and_inc");
    chk("mode_and_inc mode", {6'b0, bus.mode}, 8'h01);
    chk("mode_and_inc hour", bus.hour_bcd, 8'h01);
    op(1'b0, 1'b1, 1'b0, 1'b0, "blink_on");
    chk("blink_on blank_hr", {7'b0, bus.blank_hr}, 8'd1);
    chk("blink_on blank_min", {7'b0, bus.blank_min}, 8'd0);
    op(1'b0, 1'b1, 1'b0, 1'b0, "blink_off");
    chk("blink_off blank_hr", {7'b0, bus.blank_hr}, 8'd0);
    op(1'b0, 1'b0, 1'b1, 1'b0, "hr_to_min");
    op(1'b0, 1'b0, 1'b1, 1'b0, "min_to_run");

    // Reset lands on the cycle the tick pulse is live.
    set_hm(5, 17);
    repeat (42) op(1'b1, 1'b0, 1'b0, 1'b0, "to_051742");
    chk("051742 sec", bus.sec_bcd, 8'h42);
    @(posedge clk); #1;
    bus.clk_1hz = 1'b1;
    repeat (SYNC) @(posedge clk);
    #1;
    cr = 1'b0;
    bus.clk_1hz = 1'b0;
    @(posedge clk); #1;
    cr = 1'b1;
    model_reset();
    check_all("mid_reset");
    repeat (SYNC + 2) @(posedge clk);
    op(1'b1, 1'b0, 1'b0, 1'b0, "post_reset_tick");
    chk("post_reset sec", bus.sec_bcd, 8'h01);

    // Level already high at release gives exactly one tick.
    @(posedge clk); #1;
    cr = 1'b0;
    bus.clk_1hz = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cr = 1'b1;
    model_reset();
    repeat (SYNC + 3) @(posedge clk);
    #1;
    m_tick();
    check_all("high_at_release");
    repeat (SYNC + 4) @(posedge clk);
    #1;
    check_all("high_at_release_hold");
    bus.clk_1hz = 1'b0;
    repeat (SYNC + 2) @(posedge clk);
    #1;

    // Randomized mixes of coincident pulses in every mode.
    set_hm(23, 59);
    repeat (50) op(1'b1, 1'b0, 1'b0, 1'b0, "to_near_midnight");
    for (int i = 0; i < 160; i++) begin
      bit t1, t2, km, ki;
      t1 = ($urandom_range(0, 9) < 7);
      t2 = ($urandom_range(0, 3) == 0);
      km = ($urandom_range(0, 7) == 0);
      ki = ($urandom_range(0, 2) == 0);
      if (!(t1 | t2 | km | ki)) t1 = 1'b1;
      op(t1, t2, km, ki, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_timekeeper.md
Name: clock_timekeeper

Overview:
- Consumes the divided slow clocks (1 Hz count, 2 Hz blink) inside the 50 MHz domain and keeps 24-hour time as BCD hours/minutes/seconds.
- Synchronizes and edge-detects the divided-clock levels and the two user keys.
- Runs a RUN / SET_HR / SET_MIN mode state machine.
- Drives display-blank flags and an hourly pre-chime flag. Sits between the clock divider and the display scanner.

Parameters:
- SYNC_STAGES, 2, flip-flop stages per asynchronous-level input before edge detection (minimum 2).
- CHIME_START, 55, second (binary) at which the pre-chime window opens during minute 59.

Ports:
- clk_50m  in  1  system clock, 50 MHz.
- cr  in  1  reset; synchronous, active-low.
- clk_1hz  in  1  divided 1 Hz level; each rising edge is one seconds tick.
- clk_2hz  in  1  divided 2 Hz level; each rising edge toggles the blink phase.
- key_mode  in  1  debounced mode key, active-high level.
- key_inc  in  1  debounced increment key, active-high level.
- hour_bcd  out  8  [7:4] tens 0-2, [3:0] units 0-9.
- min_bcd  out  8  [7:4] tens 0-5, [3:0] units 0-9.
- sec_bcd  out  8  [7:4] tens 0-5, [3:0] units 0-9.
- mode  out  2  00 RUN, 01 SET_HR, 10 SET_MIN; 11 never driven.
- blank_hr  out  1  high = display blanks the hour digits.
- blank_min  out  1  high = display blanks the minute digits.
- chime  out  1  high during the hourly pre-chime window.

Behaviour:
- Reset: cr low at a clk_50m edge sets all registers to 0: time 00:00:00, mode RUN, blink 0, all sync/prev registers 0, all outputs 0.
- The divider clears its outputs on the same cr, so no spurious edge occurs at release. An input already high at release produces exactly one edge pulse.
- Edge detection, per input: SYNC_STAGES flops, then a prev register. pulse = sync_out & ~prev, lasting one cycle.
- Pulse latency: SYNC_STAGES+1 clk_50m cycles after the input rises.
- Blink: the blink register toggles on each clk_2hz pulse.
- Output flags, all registered:
  - blank_hr = (mode==SET_HR) & blink.
  - blank_min = (mode==SET_MIN) & blink.
  - chime = (mode==RUN) & (min==59) & (sec >= CHIME_START).
- Mode state machine, advanced only by a key_mode pulse: RUN -> SET_HR -> SET_MIN -> RUN.
  - On RUN -> SET_HR: sec cleared to 00 in the same cycle.
  - Seconds are frozen in both SET states.
- RUN timekeeping: a clk_1hz pulse increments sec.
  - sec 59->00 carries to min.
  - min 59->00 carries to hour.
  - hour 23->00, with no further carry.
  - 23:59:59 -> 00:00:00 in one cycle.
  - BCD units wrap 9->0 and carry to tens.
- SET_HR: a key_inc pulse increments hour modulo 24 (23->00). No carry into or out of other fields.
- SET_MIN: a key_inc pulse increments min modulo 60 (59->00). No carry into hour.
- key_inc in RUN: ignored.
- Pulse priority in the same cycle:
  - key_mode beats key_inc; key_inc is dropped.
  - In RUN, a clk_1hz pulse coinciding with key_mode is applied first, then the mode changes. Sec is cleared as part of entering SET_HR, so the result is sec=00.
  - In SET states, clk_1hz pulses are discarded.
- Reset mid-operation: synchronous reset overrides every pulse in that cycle.
- Outputs update 1 cycle after the causing pulse. Time outputs come straight from the counter registers.
- Illegal BCD (units >9, tens beyond limit) is unreachable; the next increment forces the field to 00.

Decomposition:
- Package clock_pkg holds:
  - Mode encodings MODE_RUN/MODE_SET_HR/MODE_SET_MIN.
  - Field limits SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - The BCD-pair type (8 bits).
- One sub-module, bcd_mod_counter, parameter MAX (binary).
  - Ports: clk, cr, inc, clr.
  - Outputs: bcd[7:0], carry. carry is combinational: inc & (value==MAX).
  - Instanced three times for sec, min and hour.
- Edge detectors are inline generate loops.

Test Plan:
- Reset, then 60 clk_1hz rising edges in RUN -> sec_bcd 0x00, min_bcd 0x01, hour_bcd 0x00. Each tick visible SYNC_STAGES+2 cycles after its input edge.
- Set to 23:59:58 via the key sequence, then 2 clk_1hz edges -> 23:59:59, then 00:00:00. chime high at xx:59:55 through 59 and low at 00:00:00.
- key_mode x1 at time 12:34:56 -> mode 01, sec_bcd 0x00. key_inc x13 -> hour_bcd 0x01 (12+13 mod 24). clk_1hz edges during this -> sec stays 0x00.
- mode SET_MIN with min 59, one key_inc -> min_bcd 0x00 and hour unchanged. key_mode -> mode 00, counting resumes.
- key_mode and key_inc pulses coincident in RUN -> mode 01 and hour unchanged. In SET_HR, clk_2hz edges toggle blank_hr 0->1->0 and blank_min stays 0.
- cr low for 1 cycle mid-count at 05:17:42 with a simultaneous tick -> all outputs 0, mode 00. The next clk_1hz edge gives sec_bcd 0x01.
